// File: rtl/reg_scoreboard_if.sv
// Scoreboard bundle between ID/WB/flush logic and the register scoreboard.
// The master side drives lookups, issue, retire and kill events. The slave side
// (the scoreboard) returns the hazard and the tracking status.
interface reg_scoreboard_if #(
    parameter int NREG = 32
);
    logic            ra_en;
    logic [4:0]      ra;
    logic            rb_en;
    logic [4:0]      rb;
    logic            iss_valid;
    logic            iss_we;
    logic [4:0]      iss_rd;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic            kill_valid;
    logic [4:0]      kill_rd;
    logic            stall;
    logic [NREG-1:0] busy_mask;
    logic [5:0]      inflight;
    logic            err;

    modport master (
        output ra_en, ra, rb_en, rb,
        output iss_valid, iss_we, iss_rd,
        output wb_valid, wb_rd, kill_valid, kill_rd,
        input  stall, busy_mask, inflight, err
    );

    modport slave (
        input  ra_en, ra, rb_en, rb,
        input  iss_valid, iss_we, iss_rd,
        input  wb_valid, wb_rd, kill_valid, kill_rd,
        output stall, busy_mask, inflight, err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Counted register scoreboard.
// Each register has a saturating-safe counter of in-flight writers. A decoded
// source whose counter is non-zero raises a stall, unless its only pending
// write retires this cycle and the bypass is enabled. A destination whose
// counter is full also raises a stall, so counters can never wrap.
module reg_scoreboard #(
    parameter int NREG      = 32,
    parameter int CNT_W     = 2,
    parameter int BYPASS_WB = 1
) (
    input  logic             clk,
    input  logic             rst,
    reg_scoreboard_if.slave  sb
);
    localparam int              SUM_W   = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NREG-1:0][CNT_W-1:0] cnt_reg;
    logic [NREG-1:0][CNT_W-1:0] cnt_next;
    logic [NREG-1:0]            underflow;
    logic [NREG-1:0]            busy_mask_reg;
    logic [NREG-1:0]            busy_mask_next;
    logic [5:0]                 inflight_reg;
    logic [5:0]                 inflight_next;
    logic                       inflight_clamp;
    logic                       err_reg;
    logic                       err_next;

    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic             byp_a;
    logic             byp_b;
    logic             haz_a;
    logic             haz_b;
    logic             haz_o;
    logic             stall;
    logic             acc;

    // Same-cycle hazard detection from the current counters and this cycle's events.
    always_comb begin
        cnt_a = cnt_reg[sb.ra];
        cnt_b = cnt_reg[sb.rb];
        // A single pending write that retires now (and is not also being killed) is bypassed.
        byp_a = (BYPASS_WB != 0) && (cnt_a == CNT_ONE)
                && sb.wb_valid && (sb.wb_rd == sb.ra)
                && !(sb.kill_valid && (sb.kill_rd == sb.ra));
        byp_b = (BYPASS_WB != 0) && (cnt_b == CNT_ONE)
                && sb.wb_valid && (sb.wb_rd == sb.rb)
                && !(sb.kill_valid && (sb.kill_rd == sb.rb));
        haz_a = sb.ra_en && (sb.ra != 5'd0) && (cnt_a != '0) && !byp_a;
        haz_b = sb.rb_en && (sb.rb != 5'd0) && (cnt_b != '0) && !byp_b;
        haz_o = sb.iss_we && (sb.iss_rd != 5'd0) && (cnt_reg[sb.iss_rd] == CNT_MAX);
        stall = haz_a || haz_b || haz_o;
        acc   = sb.iss_valid && sb.iss_we && (sb.iss_rd != 5'd0) && !stall;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_cnt
            if (gi == 0) begin : g_zero
                // x0 is hard-wired and never tracked.
                assign cnt_next[gi]  = '0;
                assign underflow[gi] = 1'b0;
            end else begin : g_track
                logic             inc;
                logic             wb_hit;
                logic             kill_hit;
                logic [SUM_W-1:0] cnt_sum;
                logic [SUM_W-1:0] dec;
                assign inc       = acc && (sb.iss_rd == 5'(gi));
                assign wb_hit    = sb.wb_valid && (sb.wb_rd == 5'(gi));
                assign kill_hit  = sb.kill_valid && (sb.kill_rd == 5'(gi));
                assign cnt_sum   = {1'b0, cnt_reg[gi]} + SUM_W'(inc);
                assign dec       = SUM_W'(wb_hit) + SUM_W'(kill_hit);
                // Increment and decrements net together; an excess decrement floors at zero.
                assign underflow[gi] = dec > cnt_sum;
                assign cnt_next[gi]  = underflow[gi] ? '0 : CNT_W'(cnt_sum - dec);
            end
            assign busy_mask_next[gi] = |cnt_next[gi];
        end
    endgenerate

    logic [6:0] in_sum;
    logic [6:0] in_dec;
    logic [6:0] in_diff;

    // Total outstanding writes: floor at zero flags an error, top saturates silently.
    always_comb begin
        in_sum         = {1'b0, inflight_reg} + 7'(acc);
        in_dec         = 7'(sb.wb_valid && (sb.wb_rd != 5'd0))
                       + 7'(sb.kill_valid && (sb.kill_rd != 5'd0));
        in_diff        = in_sum - in_dec;
        inflight_clamp = 1'b0;
        inflight_next  = '0;
        if (in_dec > in_sum) begin
            inflight_clamp = 1'b1;
        end else if (in_diff > 7'd63) begin
            inflight_next = 6'd63;
        end else begin
            inflight_next = in_diff[5:0];
        end
        err_next = err_reg || (|underflow) || inflight_clamp || (sb.iss_valid && stall);
    end

    // Tracking state, discarded by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg       <= '0;
            busy_mask_reg <= '0;
            inflight_reg  <= '0;
            err_reg       <= 1'b0;
        end else begin
            cnt_reg       <= cnt_next;
            busy_mask_reg <= busy_mask_next;
            inflight_reg  <= inflight_next;
            err_reg       <= err_next;
        end
    end

    assign sb.stall     = stall;
    assign sb.busy_mask = busy_mask_reg;
    assign sb.inflight  = inflight_reg;
    assign sb.err       = err_reg;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Testbench for reg_scoreboard: directed vectors with an integer model of the
// per-register writer counts, compared every cycle, plus literal spot checks.
module tb_reg_scoreboard;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_scoreboard_if #(.NREG(32)) sb_if();

    reg_scoreboard #(.NREG(32), .CNT_W(2), .BYPASS_WB(1)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: pending writers per register, total, sticky error.
    int m_cnt[32];
    int m_inflight;
    bit m_err;
    bit m_valid = 1'b0;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit src_haz(input bit en, input int idx);
        bit retiring;
        retiring = (m_cnt[idx] == 1) && sb_if.wb_valid && (int'(sb_if.wb_rd) == idx)
                   && !(sb_if.kill_valid && (int'(sb_if.kill_rd) == idx));
        return en && (idx != 0) && (m_cnt[idx] != 0) && !retiring;
    endfunction

    function automatic bit m_stall();
        bit ho;
        ho = sb_if.iss_we && (sb_if.iss_rd != 0) && (m_cnt[sb_if.iss_rd] == 3);
        return src_haz(sb_if.ra_en, int'(sb_if.ra)) || src_haz(sb_if.rb_en, int'(sb_if.rb)) || ho;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b;
        b = '0;
        for (int r = 0; r < 32; r++) b[r] = (m_cnt[r] != 0);
        return b;
    endfunction

    function automatic void m_next(output int nc[32], output int ni, output bit ne);
        bit st;
        bit acc;
        st  = m_stall();
        acc = sb_if.iss_valid && sb_if.iss_we && (sb_if.iss_rd != 0) && !st;
        ne  = m_err || (sb_if.iss_valid && st);
        for (int r = 0; r < 32; r++) begin
            nc[r] = m_cnt[r];
            if (r != 0) begin
                if (acc && int'(sb_if.iss_rd) == r) nc[r]++;
                if (sb_if.wb_valid && int'(sb_if.wb_rd) == r) nc[r]--;
                if (sb_if.kill_valid && int'(sb_if.kill_rd) == r) nc[r]--;
                if (nc[r] < 0) begin nc[r] = 0; ne = 1'b1; end
            end
        end
        ni = m_inflight;
        if (acc) ni++;
        if (sb_if.wb_valid && sb_if.wb_rd != 0) ni--;
        if (sb_if.kill_valid && sb_if.kill_rd != 0) ni--;
        if (ni < 0) begin ni = 0; ne = 1'b1; end
        if (ni > 63) ni = 63;
    endfunction

    // Model update at each active edge.
    always @(posedge clk) begin
        int nc[32];
        int ni;
        bit ne;
        if (!rst) begin
            for (int r = 0; r < 32; r++) m_cnt[r] <= 0;
            m_inflight <= 0;
            m_err      <= 1'b0;
            m_valid    <= 1'b1;
        end else if (m_valid) begin
            m_next(nc, ni, ne);
            m_cnt      <= nc;
            m_inflight <= ni;
            m_err      <= ne;
        end
    end

    // Every-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_stall",    sb_if.stall,     m_stall());
            check("cyc_busy",     sb_if.busy_mask, m_busy());
            check("cyc_inflight", sb_if.inflight,  m_inflight);
            check("cyc_err",      sb_if.err,       m_err);
        end
    end

    task automatic idle();
        sb_if.ra_en = 0; sb_if.ra = 0; sb_if.rb_en = 0; sb_if.rb = 0;
        sb_if.iss_valid = 0; sb_if.iss_we = 0; sb_if.iss_rd = 0;
        sb_if.wb_valid = 0; sb_if.wb_rd = 0; sb_if.kill_valid = 0; sb_if.kill_rd = 0;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        $display("txn %-12s busy=%08h inflight=%0d err=%0d", tag, sb_if.busy_mask, sb_if.inflight, sb_if.err);
        idle();
    endtask

    task automatic iss(input int rd);
        sb_if.iss_valid = 1; sb_if.iss_we = 1; sb_if.iss_rd = 5'(rd);
    endtask

    task automatic wb(input int rd);
        sb_if.wb_valid = 1; sb_if.wb_rd = 5'(rd);
    endtask

    task automatic do_reset();
        rst = 0;
        step("reset");
        rst = 1;
    endtask

    initial begin
        rst = 0;
        idle();
        // Reset with random activity on the inputs.
        for (int i = 0; i < 2; i++) begin
            sb_if.ra_en = 1'($urandom); sb_if.ra = 5'($urandom);
            sb_if.rb_en = 1'($urandom); sb_if.rb = 5'($urandom);
            sb_if.iss_valid = 1'($urandom); sb_if.iss_we = 1'($urandom); sb_if.iss_rd = 5'($urandom);
            sb_if.wb_valid = 1'($urandom); sb_if.wb_rd = 5'($urandom);
            sb_if.kill_valid = 1'($urandom); sb_if.kill_rd = 5'($urandom);
            step("rst_rand");
        end
        rst = 1;
        check("rst_busy", sb_if.busy_mask, 0);
        check("rst_inflight", sb_if.inflight, 0);
        check("rst_err", sb_if.err, 0);

        // RAW hazard and write-back bypass.
        iss(5); step("iss r5");
        check("raw_busy5_set", sb_if.busy_mask[5], 1);
        sb_if.ra_en = 1; sb_if.ra = 5; #1;
        check("raw_stall", sb_if.stall, 1);
        wb(5); #1;
        check("raw_bypass", sb_if.stall, 0);
        step("wb r5");
        check("raw_busy5_clr", sb_if.busy_mask[5], 0);
        check("raw_inflight", sb_if.inflight, 0);

        // Saturation on r7.
        for (int i = 0; i < 3; i++) begin iss(7); step("iss r7"); end
        check("sat_inflight", sb_if.inflight, 3);
        sb_if.iss_we = 1; sb_if.iss_rd = 7; #1;
        check("sat_stall", sb_if.stall, 1);
        step("probe r7");
        check("sat_inflight_hold", sb_if.inflight, 3);
        check("sat_err", sb_if.err, 0);
        for (int i = 0; i < 3; i++) begin wb(7); step("wb r7"); end
        check("sat_drain", sb_if.inflight, 0);

        // Same-cycle issue and retire on r9.
        iss(9); step("iss r9");
        iss(9); wb(9); step("iss+wb r9");
        check("same_inflight", sb_if.inflight, 1);
        check("same_busy9", sb_if.busy_mask[9], 1);
        wb(9); step("wb r9");

        // Double decrement on r4.
        iss(4); step("iss r4");
        iss(4); step("iss r4");
        check("dbl_pre", sb_if.inflight, 2);
        wb(4); sb_if.kill_valid = 1; sb_if.kill_rd = 4; step("wb+kill r4");
        check("dbl_inflight", sb_if.inflight, 0);
        check("dbl_busy4", sb_if.busy_mask[4], 0);
        check("dbl_err", sb_if.err, 0);

        // Source B: a kill on the same register defeats the bypass.
        iss(11); step("iss r11");
        sb_if.rb_en = 1; sb_if.rb = 11; wb(11); sb_if.kill_valid = 1; sb_if.kill_rd = 11; #1;
        check("rb_kill_nobyp", sb_if.stall, 1);
        sb_if.kill_valid = 0; #1;
        check("rb_byp", sb_if.stall, 0);
        sb_if.rb_en = 0; sb_if.wb_valid = 0; #1;
        step("idle");
        wb(11); step("wb r11");

        // Register 0 is ignored everywhere.
        iss(0); wb(0); sb_if.kill_valid = 1; sb_if.kill_rd = 0;
        sb_if.ra_en = 1; sb_if.ra = 0; sb_if.rb_en = 1; sb_if.rb = 0; #1;
        check("x0_stall", sb_if.stall, 0);
        step("x0 all");
        check("x0_inflight", sb_if.inflight, 0);
        check("x0_err", sb_if.err, 0);

        // Reset mid-operation discards tracking.
        iss(12); step("iss r12");
        do_reset();
        check("mid_busy", sb_if.busy_mask, 0);
        check("mid_inflight", sb_if.inflight, 0);

        // Issue while stalled is a protocol error and does not count.
        for (int i = 0; i < 3; i++) begin iss(7); step("iss r7"); end
        iss(7); step("iss r7 stl");
        check("stl_err", sb_if.err, 1);
        check("stl_inflight", sb_if.inflight, 3);

        // Underflow on r3 sets a sticky error.
        do_reset();
        check("uf_pre_err", sb_if.err, 0);
        wb(3); step("wb r3 uf");
        check("uf_err", sb_if.err, 1);
        check("uf_inflight", sb_if.inflight, 0);
        step("idle");
        check("uf_sticky", sb_if.err, 1);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
